seq_approx_array_divider: RTL and testbench

//  Multi-cycle restoring divider: N_WIDTH-bit dividend / D_WIDTH-bit divisor -> Q_WIDTH quotient, D_WIDTH remainder.

---
 rtl/divider_pkg.sv | 20 ++
 rtl/div_row.sv | 35 +++
 rtl/seq_approx_array_divider.sv | 145 ++++++++++++++
 tb/tb_seq_approx_array_divider.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and cell functions for the sequential restoring divider.
// Cells return {bout, diff}.
package divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int q_width(input int n_w, input int d_w);
        return n_w - d_w;
    endfunction

    function automatic logic [1:0] sub_cell_exact(input logic x, input logic y, input logic bin);
        return {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
    endfunction

    // Approx cell 243_207: borrow-in is ignored, so the row has no ripple chain.
    function automatic logic [1:0] sub_cell_approx(input logic x, input logic y);
        return {~x | y, x | ~y};
    endfunction

endpackage

// File: rtl/div_row.sv
// One combinational restoring-division row: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module div_row
    import divider_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic               approx_i,
    input  logic [D_WIDTH-1:0] rem_i,
    input  logic               n_bit_i,
    input  logic [D_WIDTH-1:0] d_i,
    output logic               q_bit_o,
    output logic [D_WIDTH-1:0] rem_o
);

    logic [D_WIDTH:0]   w;
    logic [D_WIDTH:0]   borrow;
    logic [D_WIDTH-1:0] diff;

    assign w         = {rem_i, n_bit_i};
    assign borrow[0] = 1'b0;

    for (genvar k = 0; k < D_WIDTH; k++) begin : g_cell
        logic [1:0] ex, ap;
        assign ex            = sub_cell_exact(w[k], d_i[k], borrow[k]);
        assign ap            = sub_cell_approx(w[k], d_i[k]);
        assign diff[k]       = approx_i ? ap[0] : ex[0];
        assign borrow[k+1]   = approx_i ? ap[1] : ex[1];
    end

    // The shifted-out MSB means w already exceeds any D_WIDTH-bit divisor.
    assign q_bit_o = w[D_WIDTH] | ~borrow[D_WIDTH];
    assign rem_o   = q_bit_o ? diff : w[D_WIDTH-1:0];

endmodule

// File: rtl/seq_approx_array_divider.sv
// Multi-cycle restoring divider, ROWS_PER_CYCLE chained rows per clock, MSB first;
// the lowest APPROX_ROWS rows may use the approximate subtractor cell.
module seq_approx_array_divider
    import divider_pkg::*;
#(
    parameter int  N_WIDTH        = 16,
    parameter int  D_WIDTH        = 8,
    parameter int  APPROX_ROWS    = 6,
    parameter int  ROWS_PER_CYCLE = 1,
    localparam int Q_WIDTH        = q_width(N_WIDTH, D_WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               approx_en_i,
    input  logic [N_WIDTH-1:0] n_i,
    input  logic [D_WIDTH-1:0] d_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [Q_WIDTH-1:0] q_o,
    output logic [D_WIDTH-1:0] r_o,
    output logic               ovf_o
);

    localparam int ROW_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

    state_e             state_q, state_d;
    logic [Q_WIDTH-1:0] n_lo_q, n_lo_d;
    logic [D_WIDTH-1:0] d_q, d_d;
    logic               approx_q, approx_d;
    logic [D_WIDTH-1:0] rem_q, rem_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [Q_WIDTH-1:0] qacc_q, qacc_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [Q_WIDTH-1:0] q_q, q_d;
    logic [D_WIDTH-1:0] r_q, r_d;
    logic               ovf_q, ovf_d;

    logic [ROWS_PER_CYCLE:0][D_WIDTH-1:0] rem_chain;
    logic [ROWS_PER_CYCLE-1:0][ROW_W-1:0] row_idx;
    logic [ROWS_PER_CYCLE-1:0]            q_bits;

    assign rem_chain[0] = rem_q;

    // Row j of this cycle handles quotient bit row_q - j, so rows stay strictly ordered.
    for (genvar j = 0; j < ROWS_PER_CYCLE; j++) begin : g_row
        assign row_idx[j] = row_q - ROW_W'(j);
        div_row #(.D_WIDTH(D_WIDTH)) u_row (
            .approx_i (approx_q && (int'(row_idx[j]) < APPROX_ROWS)),
            .rem_i    (rem_chain[j]),
            .n_bit_i  (n_lo_q[row_idx[j]]),
            .d_i      (d_q),
            .q_bit_o  (q_bits[j]),
            .rem_o    (rem_chain[j+1])
        );
    end

    always_comb begin
        state_d    = state_q;
        n_lo_d     = n_lo_q;
        d_d        = d_q;
        approx_d   = approx_q;
        rem_d      = rem_q;
        row_d      = row_q;
        qacc_d     = qacc_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        q_d        = q_q;
        r_d        = r_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d    = RUN;
                n_lo_d     = n_i[Q_WIDTH-1:0];
                d_d        = d_i;
                approx_d   = approx_en_i;
                rem_d      = n_i[N_WIDTH-1:Q_WIDTH];
                row_d      = ROW_W'(Q_WIDTH - 1);
                qacc_d     = '0;
                ovf_pend_d = (n_i[N_WIDTH-1:Q_WIDTH] >= d_i);
                busy_d     = 1'b1;
            end
            RUN: begin
                rem_d = rem_chain[ROWS_PER_CYCLE];
                for (int j = 0; j < ROWS_PER_CYCLE; j++) qacc_d[row_idx[j]] = q_bits[j];
                if (row_q == ROW_W'(ROWS_PER_CYCLE - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end else begin
                    row_d = row_q - ROW_W'(ROWS_PER_CYCLE);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                q_d     = qacc_q;
                r_d     = rem_q;
                ovf_d   = ovf_pend_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_lo_q     <= '0;
            d_q        <= '0;
            approx_q   <= 1'b0;
            rem_q      <= '0;
            row_q      <= '0;
            qacc_q     <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_lo_q     <= n_lo_d;
            d_q        <= d_d;
            approx_q   <= approx_d;
            rem_q      <= rem_d;
            row_q      <= row_d;
            qacc_q     <= qacc_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            q_q        <= q_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign q_o    = q_q;
    assign r_o    = r_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_approx_array_divider.sv
// Directed bench: instance 0 (one row per clock) carries the handshake/reset vectors,
// all four instances (1,2,4,8 rows per clock) are swept against a reference model.
module tb_seq_approx_array_divider;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic approx_en = 1'b0;
    logic [15:0] n_in = '0;
    logic [7:0]  d_in = '0;
    logic [NI-1:0] busy, done, ovf;
    logic [NI-1:0][7:0] q, r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_approx_array_divider #(
            .N_WIDTH(16), .D_WIDTH(8), .APPROX_ROWS(6), .ROWS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start_i(start), .approx_en_i(approx_en),
            .n_i(n_in), .d_i(d_in), .busy_o(busy[g]), .done_o(done[g]),
            .q_o(q[g]), .r_o(r[g]), .ovf_o(ovf[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; the start is sampled on the next edge (cycle 0).
    task automatic kick(input logic [15:0] nn, input logic [7:0] dd, input logic ap);
        start = 1'b1; n_in = nn; d_in = dd; approx_en = ap;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done[0]) begin lat = c; break; end
        end
    endtask

    // Exact rows as integer compare/subtract; approx rows from the cell equations.
    function automatic logic [15:0] ref_div(input logic [15:0] nn, input logic [7:0] dd, input logic ap);
        logic [7:0] rem;
        logic [8:0] w;
        logic [7:0] qq;
        rem = nn[15:8];
        qq  = '0;
        for (int i = 7; i >= 0; i--) begin
            w = {rem, nn[i]};
            if (ap && i < 6) begin
                qq[i] = w[8] | (w[7] & ~dd[7]);
                rem   = qq[i] ? (w[7:0] | ~dd) : w[7:0];
            end else begin
                qq[i] = w[8] | (w[7:0] >= dd);
                rem   = qq[i] ? (w[7:0] - dd) : w[7:0];
            end
        end
        return {qq, rem};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ndone, first;
        logic [7:0] qsave;
        logic [15:0] sv_n[6];
        logic [7:0]  sv_d[6];
        logic        sv_a[6];
        int          s_lat[NI];
        logic [7:0]  s_q[NI], s_r[NI];
        logic        s_o[NI];
        logic [15:0] refv;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q",    q[0], 0);
        check("rst_r",    r[0], 0);
        check("rst_ovf",  ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1000/25 exact
        kick(16'd1000, 8'd25, 1'b0);
        check("t1_busy", busy[0], 1);
        wait_done(lat);
        check("t1_lat", lat, 9);
        check("t1_q", q[0], 40);
        check("t1_r", r[0], 0);
        check("t1_ovf", ovf[0], 0);
        check("t1_busy_done", busy[0], 0);

        kick(16'h00FF, 8'd1, 1'b0);
        wait_done(lat);
        check("t2_q", q[0], 8'hFF);
        check("t2_r", r[0], 0);

        kick(16'h00FF, 8'd1, 1'b1);
        wait_done(lat);
        check("t3_q", q[0], 8'hC0);
        check("t3_r", r[0], 8'h3F);

        kick(16'hFF00, 8'h10, 1'b0);
        wait_done(lat);
        check("t4a_lat", lat, 9);
        check("t4a_ovf", ovf[0], 1);
        check("t4a_q", q[0], 8'hF0);
        check("t4a_r", r[0], 0);

        kick(16'hFF00, 8'h00, 1'b0);
        wait_done(lat);
        check("t4b_lat", lat, 9);
        check("t4b_ovf", ovf[0], 1);
        check("t4b_q", q[0], 8'hFF);
        check("t4b_r", r[0], 0);

        // Second start during RUN must be dropped.
        kick(16'd1000, 8'd25, 1'b0);
        ndone = 0; first = -1; qsave = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin start = 1'b1; n_in = 16'd500; d_in = 8'd7; end
            if (c == 4) start = 1'b0;
            if (done[0]) begin
                ndone++;
                if (first < 0) begin first = c; qsave = q[0]; end
            end
        end
        check("t5_ndone", ndone, 1);
        check("t5_lat", first, 9);
        check("t5_q", qsave, 40);

        // Start in the cycle after done completes is accepted.
        kick(16'd1000, 8'd25, 1'b0);
        wait_done(lat);
        check("t5b_lat1", lat, 9);
        kick(16'h00FF, 8'd1, 1'b0);
        check("t5b_busy", busy[0], 1);
        wait_done(lat);
        check("t5b_lat2", lat, 9);
        check("t5b_q", q[0], 8'hFF);

        // Async reset mid-run.
        kick(16'h00FF, 8'd1, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_busy", busy[0], 0);
        check("t6_done", done[0], 0);
        check("t6_q", q[0], 0);
        check("t6_r", r[0], 0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done[0]) ndone++;
        end
        check("t6_nodone", ndone, 0);

        // Sweep rows-per-cycle.
        sv_n = '{16'd1000, 16'h00FF, 16'hFF00, 16'h1234, 16'hABCD, 16'hFFFF};
        sv_d = '{8'd25,    8'd1,     8'h10,    8'h37,    8'hC3,    8'h00};
        sv_a = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b1};
        for (int v = 0; v < 6; v++) begin
            for (int g = 0; g < NI; g++) begin s_lat[g] = -1; s_q[g] = '0; s_r[g] = '0; s_o[g] = 1'b0; end
            kick(sv_n[v], sv_d[v], sv_a[v]);
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < NI; g++)
                    if (done[g] && s_lat[g] < 0) begin
                        s_lat[g] = c; s_q[g] = q[g]; s_r[g] = r[g]; s_o[g] = ovf[g];
                    end
            end
            refv = ref_div(sv_n[v], sv_d[v], sv_a[v]);
            for (int g = 0; g < NI; g++) begin
                check($sformatf("sw%0d_rpc%0d_lat", v, 1 << g), s_lat[g], 8 / (1 << g) + 1);
                check($sformatf("sw%0d_rpc%0d_q", v, 1 << g), s_q[g], refv[15:8]);
                check($sformatf("sw%0d_rpc%0d_r", v, 1 << g), s_r[g], refv[7:0]);
                check($sformatf("sw%0d_rpc%0d_ovf", v, 1 << g), s_o[g], sv_n[v][15:8] >= sv_d[v]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
